// File: rtl/decoder_pkg.sv
// Shared widths, field offsets and the decoded-entry type for the decode stage.
// Offsets are measured from the LSB of the raw instruction word.
package decoder_pkg;

    localparam int unsigned COND_W  = 2;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned NUM_OPS = 6;
    localparam int unsigned INSTR_W = COND_W + OP_W + 3 * REG_W + SHIFT_W;

    localparam int unsigned SHIFT_LSB = 0;
    localparam int unsigned SRC2_LSB  = SHIFT_LSB + SHIFT_W;
    localparam int unsigned SRC1_LSB  = SRC2_LSB + REG_W;
    localparam int unsigned DEST_LSB  = SRC1_LSB + REG_W;
    localparam int unsigned OP_LSB    = DEST_LSB + REG_W;
    localparam int unsigned COND_LSB  = OP_LSB + OP_W;

    typedef struct packed {
        logic [COND_W-1:0]  condition;
        logic [OP_W-1:0]    op_code;
        logic [REG_W-1:0]   dest_reg;
        logic [REG_W-1:0]   source_reg_one;
        logic [REG_W-1:0]   source_reg_two;
        logic [SHIFT_W-1:0] bits_to_shift;
        logic               illegal_op;
        logic [SEQ_W-1:0]   seq_id;
    } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational field slicer: splits a raw instruction word and flags opcodes
// outside the legal range.
module decode_fields #(
    parameter int unsigned COND_W  = decoder_pkg::COND_W,
    parameter int unsigned OP_W    = decoder_pkg::OP_W,
    parameter int unsigned REG_W   = decoder_pkg::REG_W,
    parameter int unsigned SHIFT_W = decoder_pkg::SHIFT_W,
    parameter int unsigned INSTR_W = COND_W + OP_W + 3 * REG_W + SHIFT_W,
    parameter int unsigned NUM_OPS = decoder_pkg::NUM_OPS
) (
    input  logic [INSTR_W-1:0] raw_instruction,
    output logic [COND_W-1:0]  condition,
    output logic [OP_W-1:0]    op_code,
    output logic [REG_W-1:0]   dest_reg,
    output logic [REG_W-1:0]   source_reg_one,
    output logic [REG_W-1:0]   source_reg_two,
    output logic [SHIFT_W-1:0] bits_to_shift,
    output logic               illegal_op
);

    localparam int unsigned SrcTwoLsb = SHIFT_W;
    localparam int unsigned SrcOneLsb = SrcTwoLsb + REG_W;
    localparam int unsigned DestLsb   = SrcOneLsb + REG_W;
    localparam int unsigned OpLsb     = DestLsb + REG_W;
    localparam int unsigned CondLsb   = OpLsb + OP_W;

    assign condition      = raw_instruction[CondLsb +: COND_W];
    assign op_code        = raw_instruction[OpLsb +: OP_W];
    assign dest_reg       = raw_instruction[DestLsb +: REG_W];
    assign source_reg_one = raw_instruction[SrcOneLsb +: REG_W];
    assign source_reg_two = raw_instruction[SrcTwoLsb +: REG_W];
    assign bits_to_shift  = raw_instruction[0 +: SHIFT_W];

    assign illegal_op = (32'(op_code) >= NUM_OPS);

endmodule

// File: rtl/instr_decode_stage.sv
// Pipelined instruction-decode stage: decodes on the input path, tags each
// accepted word with a wrapping sequence number and delivers via a 2-entry skid buffer.
module instr_decode_stage #(
    parameter int unsigned COND_W  = decoder_pkg::COND_W,
    parameter int unsigned OP_W    = decoder_pkg::OP_W,
    parameter int unsigned REG_W   = decoder_pkg::REG_W,
    parameter int unsigned SHIFT_W = decoder_pkg::SHIFT_W,
    parameter int unsigned INSTR_W = COND_W + OP_W + 3 * REG_W + SHIFT_W,
    parameter int unsigned NUM_OPS = decoder_pkg::NUM_OPS,
    parameter int unsigned SEQ_W   = decoder_pkg::SEQ_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] raw_instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COND_W-1:0]  condition,
    output logic [OP_W-1:0]    op_code,
    output logic [REG_W-1:0]   dest_reg,
    output logic [REG_W-1:0]   source_reg_one,
    output logic [REG_W-1:0]   source_reg_two,
    output logic [SHIFT_W-1:0] bits_to_shift,
    output logic               illegal_op,
    output logic [SEQ_W-1:0]   seq_id
);

    if (INSTR_W != COND_W + OP_W + 3 * REG_W + SHIFT_W) begin : g_bad_instr_w
        $error("instr_decode_stage: INSTR_W must equal the sum of the field widths");
    end

    typedef struct packed {
        logic [COND_W-1:0]  condition;
        logic [OP_W-1:0]    op_code;
        logic [REG_W-1:0]   dest_reg;
        logic [REG_W-1:0]   source_reg_one;
        logic [REG_W-1:0]   source_reg_two;
        logic [SHIFT_W-1:0] bits_to_shift;
        logic               illegal_op;
        logic [SEQ_W-1:0]   seq_id;
    } entry_t;

    logic [COND_W-1:0]  w_condition;
    logic [OP_W-1:0]    w_op_code;
    logic [REG_W-1:0]   w_dest_reg;
    logic [REG_W-1:0]   w_source_reg_one;
    logic [REG_W-1:0]   w_source_reg_two;
    logic [SHIFT_W-1:0] w_bits_to_shift;
    logic               w_illegal_op;
    entry_t             w_new;

    entry_t             r_main;
    entry_t             r_skid;
    logic               r_main_valid;
    logic               r_skid_valid;
    logic [SEQ_W-1:0]   r_seq;

    logic               w_in_xfer;
    logic               w_out_xfer;

    decode_fields #(
        .COND_W  (COND_W),
        .OP_W    (OP_W),
        .REG_W   (REG_W),
        .SHIFT_W (SHIFT_W),
        .INSTR_W (INSTR_W),
        .NUM_OPS (NUM_OPS)
    ) u_decode_fields (
        .raw_instruction (raw_instruction),
        .condition       (w_condition),
        .op_code         (w_op_code),
        .dest_reg        (w_dest_reg),
        .source_reg_one  (w_source_reg_one),
        .source_reg_two  (w_source_reg_two),
        .bits_to_shift   (w_bits_to_shift),
        .illegal_op      (w_illegal_op)
    );

    always_comb begin
        w_new                = '0;
        w_new.condition      = w_condition;
        w_new.op_code        = w_op_code;
        w_new.dest_reg       = w_dest_reg;
        w_new.source_reg_one = w_source_reg_one;
        w_new.source_reg_two = w_source_reg_two;
        w_new.bits_to_shift  = w_bits_to_shift;
        w_new.illegal_op     = w_illegal_op;
        w_new.seq_id         = r_seq;
    end

    // in_ready depends only on flop state, so out_ready never reaches it combinationally.
    assign in_ready   = !r_skid_valid;
    assign w_in_xfer  = in_valid && !r_skid_valid;
    assign w_out_xfer = r_main_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_seq        <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (!r_main_valid || w_out_xfer) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_main       <= w_new;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                r_skid       <= w_new;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid      = r_main_valid;
    assign condition      = r_main.condition;
    assign op_code        = r_main.op_code;
    assign dest_reg       = r_main.dest_reg;
    assign source_reg_one = r_main.source_reg_one;
    assign source_reg_two = r_main.source_reg_two;
    assign bits_to_shift  = r_main.bits_to_shift;
    assign illegal_op     = r_main.illegal_op;
    assign seq_id         = r_main.seq_id;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: a scoreboard of expected entries
// is filled on input transfers and drained on output transfers.
module tb_instr_decode_stage;
    import decoder_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] raw_instruction = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [COND_W-1:0]  condition;
    logic [OP_W-1:0]    op_code;
    logic [REG_W-1:0]   dest_reg;
    logic [REG_W-1:0]   source_reg_one;
    logic [REG_W-1:0]   source_reg_two;
    logic [SHIFT_W-1:0] bits_to_shift;
    logic               illegal_op;
    logic [SEQ_W-1:0]   seq_id;

    int                 checks = 0;
    int                 errors = 0;
    decoded_t           sb[$];
    logic [SEQ_W-1:0]   seq_m = '0;
    decoded_t           dut_out;
    decoded_t           mon_exp;

    instr_decode_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .raw_instruction (raw_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .condition       (condition),
        .op_code         (op_code),
        .dest_reg        (dest_reg),
        .source_reg_one  (source_reg_one),
        .source_reg_two  (source_reg_two),
        .bits_to_shift   (bits_to_shift),
        .illegal_op      (illegal_op),
        .seq_id          (seq_id)
    );

    always #5 clk = ~clk;

    assign dut_out = {condition, op_code, dest_reg, source_reg_one, source_reg_two,
                      bits_to_shift, illegal_op, seq_id};

    function automatic decoded_t model(input logic [INSTR_W-1:0] w, input logic [SEQ_W-1:0] s);
        decoded_t d;
        d.condition      = w[COND_LSB +: COND_W];
        d.op_code        = w[OP_LSB +: OP_W];
        d.dest_reg       = w[DEST_LSB +: REG_W];
        d.source_reg_one = w[SRC1_LSB +: REG_W];
        d.source_reg_two = w[SRC2_LSB +: REG_W];
        d.bits_to_shift  = w[SHIFT_LSB +: SHIFT_W];
        d.illegal_op     = (int'(d.op_code) >= int'(NUM_OPS));
        d.seq_id         = s;
        return d;
    endfunction

    // Scoreboard: pop on output transfer, drop everything on flush, push on input transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output got %h, required no output", dut_out);
                end else begin
                    mon_exp = sb.pop_front();
                    if (dut_out !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_entry got %h, required %h", dut_out, mon_exp);
                    end
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(model(raw_instruction, seq_m));
                seq_m = seq_m + 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        sb.delete();
        seq_m = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (sb.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain got pending=%0d out_valid=%b, required pending=0 out_valid=0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, illegal_op, seq_id} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b ill=%b seq=%0d, required 1 0 0 0",
                     in_ready, out_valid, illegal_op, seq_id);
        end
        checks++;
        if (dut_out !== '0) begin
            errors++;
            $display("FAIL reset_fields got %h, required 0", dut_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        raw_instruction = 16'hB6E7;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 ||
            dut_out !== {2'd2, 3'd6, 3'd6, 3'd7, 3'd1, 2'd3, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL single_b6e7 got vld=%b %h, required vld=1 %h", out_valid, dut_out,
                     {2'd2, 3'd6, 3'd6, 3'd7, 3'd1, 2'd3, 1'b1, 4'd0});
        end
        drain();
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            raw_instruction = 16'($urandom);
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || seq_id !== 4'(i)) begin
                errors++;
                $display("FAIL stream_%0d got vld=%b rdy=%b seq=%0d, required 1 1 %0d",
                         i, out_valid, in_ready, seq_id, i % 16);
            end
        end
        drain();
    endtask

    task automatic test_stall();
        decoded_t held;
        out_ready = 1'b0;
        in_valid = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_edge1 got rdy=%b vld=%b, required 1 1", in_ready, out_valid);
        end
        held = dut_out;
        for (int e = 2; e <= 3; e++) begin
            raw_instruction = 16'($urandom);
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_out !== held) begin
                errors++;
                $display("FAIL stall_edge%0d got rdy=%b vld=%b %h, required 0 1 %h",
                         e, in_ready, out_valid, dut_out, held);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got rdy=%b vld=%b, required 1 1", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            raw_instruction = 16'($urandom);
            tick();
        end
        drain();
    endtask

    task automatic test_flush();
        logic [SEQ_W-1:0] s0 = seq_m;
        out_ready = 1'b0;
        in_valid = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        raw_instruction = 16'($urandom);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got rdy=%b vld=%b, required 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_both got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        flush = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_inxfer got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        raw_instruction = 16'($urandom);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || seq_id !== SEQ_W'(s0 + 3)) begin
            errors++;
            $display("FAIL flush_next_seq got vld=%b seq=%0d, required 1 %0d",
                     out_valid, seq_id, SEQ_W'(s0 + 3));
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raw_instruction = 16'($urandom);
            tick();
        end
        #2;
        reset_n = 1'b0;
        sb.delete();
        seq_m = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dut_out !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b %h, required 1 0 0",
                     in_ready, out_valid, dut_out);
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        in_valid = 1'b1;
        raw_instruction = 16'($urandom);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || seq_id !== '0) begin
            errors++;
            $display("FAIL post_reset_seq got vld=%b seq=%0d, required 1 0", out_valid, seq_id);
        end
        drain();
    endtask

    task automatic test_zero();
        raw_instruction = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dut_out[$bits(decoded_t)-1:SEQ_W] !== '0) begin
            errors++;
            $display("FAIL zero_word got vld=%b %h, required vld=1 fields 0", out_valid, dut_out);
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Parametrised, pipelined instruction-decode stage.
- Accepts raw instruction words over a valid/ready handshake and splits each into condition, opcode, register and shift fields.
- Flags illegal opcodes and tags every accepted instruction with a wrapping sequence number.
- Delivers results through a two-entry skid buffer, so `in_ready` is registered and back-pressure never forms a combinational path.
- Sits between the fetch unit and the register-read/execute stage.

## Interface
Parameters:
- `COND_W`, 2, condition field width
- `OP_W`, 3, opcode field width
- `REG_W`, 3, register-index field width (dest, src one, src two)
- `SHIFT_W`, 2, shift-amount field width
- `INSTR_W`, `COND_W+OP_W+3*REG_W+SHIFT_W` (16), instruction width; any other value is an elaboration error
- `NUM_OPS`, 6, opcodes `0..NUM_OPS-1` are legal
- `SEQ_W`, 4, sequence-tag width

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous pipeline flush
- `in_valid` in 1; `in_ready` out 1; `raw_instruction` in `INSTR_W`
- `out_valid` out 1; `out_ready` in 1
- `condition` out `COND_W`; `op_code` out `OP_W`
- `dest_reg`, `source_reg_one`, `source_reg_two` out `REG_W` each
- `bits_to_shift` out `SHIFT_W`
- `illegal_op` out 1: high when `op_code >= NUM_OPS`
- `seq_id` out `SEQ_W`: tag of the presented instruction

## Operation
- Field layout, MSB to LSB: condition, opcode, dest, src one, src two, shift. With the defaults: [15:14], [13:11], [10:8], [7:5], [4:2], [1:0].
- Decoded fields, `illegal_op` and `seq_id` form one entry. Entries are stored in a main (output) register and a skid register, each with its own valid bit.
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- `in_ready` = !skid_valid, taken from a register only.
- `out_valid` = main_valid. All data outputs are driven only from the main register.
- Main register loads when it is empty or an output transfer occurs:
  - from skid if skid_valid, which also clears skid_valid;
  - otherwise from the input on an input transfer;
  - otherwise main_valid is cleared.
- Skid register loads on an input transfer while main is full and no output transfer occurs (main keeps its entry).
- Entries leave in exactly the order they arrived; none is duplicated or lost.
- Sequence counter starts at 0, increments by 1 on every non-flushed input transfer, and wraps from `2^SEQ_W-1` to 0. Each entry carries the counter value at the moment it was accepted.
- `illegal_op` is informational only; illegal instructions pass through like any other.
- `flush` has priority over everything else:
  - next edge clears main_valid and skid_valid;
  - an input transfer in the same cycle is discarded and does not increment the counter;
  - an output transfer in the same cycle counts as consumed;
  - the sequence counter is not reset.
- `reset_n` low, including mid-transfer: all state clears immediately.

## Timing
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N. Throughput is 1 per cycle while `out_ready`=1.
- With `out_ready` low for one cycle, one extra word is absorbed by the skid register and `in_ready` drops after that edge.
- `in_ready` returns high one cycle after main drains from skid.
- Reset values: `in_ready`=1, `out_valid`=0, `illegal_op`=0, `seq_id`=0, all field outputs 0.
- After `flush`: `out_valid`=0 and `in_ready`=1 from the next edge.
- Data outputs are stable while `out_valid && !out_ready`.

## Structure
- Shared package `decoder_pkg`:
  - default field widths;
  - field-offset constants derived from the widths;
  - `NUM_OPS` default;
  - the packed decoded-entry struct type.
- One combinational sub-module, `decode_fields`: slices the raw word and computes `illegal_op`. It is instantiated once, on the input path.
- Top-level module holds the main/skid registers, valid bits, the sequence counter and flush logic.

## Test plan
- Reset, then a single `raw_instruction`=16'hB6E7 with `out_ready`=1 → one cycle later `condition`=2, `op_code`=6, `dest_reg`=6, `source_reg_one`=7, `source_reg_two`=1, `bits_to_shift`=3, `illegal_op`=1, `seq_id`=0.
- Streaming 20 words with `out_ready`=1 → 20 outputs in order, one per cycle, with `seq_id` running 0..15, 0..3 (wrap).
- `out_ready` low for 3 cycles while `in_valid` stays high → exactly 2 words held (main + skid), `in_ready`=0 from the second stalled edge, and no loss or reorder on release.
- `flush` asserted with both registers full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the dropped words never appear. The next accepted word's `seq_id` follows the last non-flushed accept.
- `reset_n` pulsed low asynchronously mid-stream → outputs reach reset values immediately, and the first word after reset gets `seq_id`=0.
- Word 16'h0000 → all fields 0, `illegal_op`=0.
